// File: rtl/dsp_mem_pkg.sv
// Shared definitions for the DSP data memory: read-during-write mode codes and byte-merge helper.
package dsp_mem_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // be_merge works on a wide fixed word; callers size-cast in and out of it.
    localparam int MERGE_MAX_W = 512;
    typedef logic [MERGE_MAX_W-1:0]   merge_word_t;
    typedef logic [MERGE_MAX_W/8-1:0] merge_be_t;

    function automatic merge_word_t be_merge(merge_word_t old_w, merge_word_t new_w, merge_be_t be);
        merge_word_t res;
        res = old_w;
        for (int i = 0; i < MERGE_MAX_W/8; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_dp_be_param_if.sv
// Bus bundle for both ports of dmem_dp_be_param plus the collision strobe.
// Request side: en is a single-cycle request that the memory always accepts (no ready);
// response side: rvalid qualifies rdata exactly LAT cycles after the request, no back-pressure.
interface dmem_dp_be_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BE_W   = DATA_W/8
);
    logic              a_en;
    logic              a_we;
    logic [BE_W-1:0]   a_be;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_rvalid;

    logic              b_en;
    logic              b_we;
    logic [BE_W-1:0]   b_be;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;
    logic              b_rvalid;

    logic              collision;

    modport master (
        output a_en, a_we, a_be, a_addr, a_wdata,
        output b_en, b_we, b_be, b_addr, b_wdata,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid, collision
    );

    modport slave (
        input  a_en, a_we, a_be, a_addr, a_wdata,
        input  b_en, b_we, b_be, b_addr, b_wdata,
        output a_rdata, a_rvalid, b_rdata, b_rvalid, collision
    );

endinterface

// File: rtl/dmem_rd_pipe.sv
// Per-port read return pipe: rdata/rvalid registers with reset flush.
// DMEM_OUT_PIPE_EN adds a second output register stage.
module dmem_rd_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] acc_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    // Data only loads on an access so rdata holds between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= acc_en;
            if (acc_en) s1_data <= acc_data;
        end
    end

`ifdef DMEM_OUT_PIPE_EN
    logic [DATA_W-1:0] s2_data;
    logic              s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_data  <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_data <= s1_data;
        end
    end

    assign rdata  = s2_data;
    assign rvalid = s2_valid;
`else
    assign rdata  = s1_data;
    assign rvalid = s1_valid;
`endif

endmodule

// File: rtl/dmem_dp_be_param.sv
// True-dual-port byte-enable data memory with same-address arbitration and collision strobe.
// Optional macro DMEM_OUT_PIPE_EN adds one output register stage on rdata/rvalid/collision.
module dmem_dp_be_param
    import dsp_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BE_W      = DATA_W/8,
    parameter int RDW_A     = 0,
    parameter int RDW_B     = 0,
    parameter     INIT_FILE = "dmem_init.mem"
) (
    input  logic              clk,
    input  logic              rst,
    dmem_dp_be_param_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam bit A_WF = (RDW_A == RDW_WRITE_FIRST);
    localparam bit B_WF = (RDW_B == RDW_WRITE_FIRST);

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [DATA_W-1:0] merge(logic [DATA_W-1:0] old_w,
                                                logic [DATA_W-1:0] new_w,
                                                logic [BE_W-1:0]   be);
        return DATA_W'(be_merge(merge_word_t'(old_w), merge_word_t'(new_w), merge_be_t'(be)));
    endfunction

    logic              a_acc, b_acc, a_in, b_in, a_wr, b_wr, same_addr, both_wr;
    logic [ADDR_W-1:0] a_idx, b_idx;
    logic [DATA_W-1:0] a_old, b_old, a_new, b_new, both_word, a_rd_word, b_rd_word;
    logic              collision_now;

    // Accesses presented during reset are dropped entirely.
    assign a_acc = bus.a_en & ~rst;
    assign b_acc = bus.b_en & ~rst;
    assign a_in  = ({1'b0, bus.a_addr} < DEPTH_C);
    assign b_in  = ({1'b0, bus.b_addr} < DEPTH_C);
    assign a_idx = a_in ? bus.a_addr : '0;
    assign b_idx = b_in ? bus.b_addr : '0;

    assign a_wr = a_acc & bus.a_we & (|bus.a_be) & a_in;
    assign b_wr = b_acc & bus.b_we & (|bus.b_be) & b_in;
    assign same_addr = (bus.a_addr == bus.b_addr);
    assign both_wr   = a_wr & b_wr & same_addr;

    assign a_old = a_in ? mem[a_idx] : '0;
    assign b_old = b_in ? mem[b_idx] : '0;
    assign a_new = merge(a_old, bus.a_wdata, bus.a_be);
    assign b_new = merge(b_old, bus.b_wdata, bus.b_be);
    // On a double write B lands first, then A overrides the overlapping bytes.
    assign both_word = merge(b_new, bus.a_wdata, bus.a_be);

    // Cross-port reads see pre-edge contents; only the own-port merge is ever forwarded.
    assign a_rd_word = !a_in ? '0 : ((bus.a_we && A_WF) ? a_new : a_old);
    assign b_rd_word = !b_in ? '0 : ((bus.b_we && B_WF) ? b_new : b_old);

    assign collision_now = a_acc & b_acc & same_addr & (bus.a_we | bus.b_we) & a_in;

    always_ff @(posedge clk) begin
        if (both_wr) begin
            mem[a_idx] <= both_word;
        end else begin
            if (a_wr) mem[a_idx] <= a_new;
            if (b_wr) mem[b_idx] <= b_new;
        end
    end

    dmem_rd_pipe #(.DATA_W(DATA_W)) u_pipe_a (
        .clk      (clk),
        .rst      (rst),
        .acc_en   (a_acc),
        .acc_data (a_rd_word),
        .rdata    (bus.a_rdata),
        .rvalid   (bus.a_rvalid)
    );

    dmem_rd_pipe #(.DATA_W(DATA_W)) u_pipe_b (
        .clk      (clk),
        .rst      (rst),
        .acc_en   (b_acc),
        .acc_data (b_rd_word),
        .rdata    (bus.b_rdata),
        .rvalid   (bus.b_rvalid)
    );

    logic col_q1;

    always_ff @(posedge clk) begin
        if (rst) col_q1 <= 1'b0;
        else     col_q1 <= collision_now;
    end

`ifdef DMEM_OUT_PIPE_EN
    logic col_q2;

    always_ff @(posedge clk) begin
        if (rst) col_q2 <= 1'b0;
        else     col_q2 <= col_q1;
    end

    assign bus.collision = col_q2;
`else
    assign bus.collision = col_q1;
`endif

endmodule

// File: tb/tb_dmem_dp_be_param.sv
// Bench for dmem_dp_be_param: vector table through a latency-aware expected queue,
// plus hand sequences for reset-dropped accesses and in-flight flush.
module tb_dmem_dp_be_param;
    import dsp_mem_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1000;
`ifdef DMEM_OUT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [1:0] OP_I = 2'd0, OP_R = 2'd1, OP_W = 2'd2;

    typedef struct packed {
        int          tag;
        logic        ea_v;
        logic        ea_chk;
        logic [31:0] ea_d;
        logic        eb_v;
        logic        eb_chk;
        logic [31:0] eb_d;
        logic        ecol;
    } exp_t;

    typedef struct {
        logic [1:0]  a_op;
        logic [3:0]  a_be;
        logic [9:0]  a_addr;
        logic [31:0] a_wd;
        logic [1:0]  b_op;
        logic [3:0]  b_be;
        logic [9:0]  b_addr;
        logic [31:0] b_wd;
        exp_t        e;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_dp_be_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    dmem_dp_be_param #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .RDW_A     (RDW_WRITE_FIRST),
        .RDW_B     (RDW_READ_FIRST),
        .INIT_FILE ("")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // scoreboard
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   tag_no = 0;
    vec_t vecs[25];

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s tag=%0d: got %h want %h", nm, tag, act, want);
        end
    endtask

    function automatic exp_t ex(logic av, logic ac, logic [31:0] ad,
                                logic bv, logic bc, logic [31:0] bd, logic col);
        exp_t e;
        e.tag = 0; e.ea_v = av; e.ea_chk = ac; e.ea_d = ad;
        e.eb_v = bv; e.eb_chk = bc; e.eb_d = bd; e.ecol = col;
        return e;
    endfunction

    function automatic vec_t mk(logic [1:0] a_op, logic [3:0] a_be, logic [9:0] a_addr, logic [31:0] a_wd,
                                logic [1:0] b_op, logic [3:0] b_be, logic [9:0] b_addr, logic [31:0] b_wd,
                                exp_t e);
        vec_t v;
        v.a_op = a_op; v.a_be = a_be; v.a_addr = a_addr; v.a_wd = a_wd;
        v.b_op = b_op; v.b_be = b_be; v.b_addr = b_addr; v.b_wd = b_wd;
        v.e = e;
        return v;
    endfunction

    // driver: apply one access cycle, push its expectation, compare the one due now
    task automatic run(input vec_t v);
        exp_t e;
        bus.a_en    = (v.a_op != OP_I);
        bus.a_we    = (v.a_op == OP_W);
        bus.a_be    = v.a_be;
        bus.a_addr  = v.a_addr;
        bus.a_wdata = v.a_wd;
        bus.b_en    = (v.b_op != OP_I);
        bus.b_we    = (v.b_op == OP_W);
        bus.b_be    = v.b_be;
        bus.b_addr  = v.b_addr;
        bus.b_wdata = v.b_wd;
        e = v.e;
        e.tag = tag_no;
        tag_no++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() >= LAT) begin
            e = exp_q.pop_front();
            chk("a_rvalid", e.tag, 32'(bus.a_rvalid), 32'(e.ea_v));
            chk("b_rvalid", e.tag, 32'(bus.b_rvalid), 32'(e.eb_v));
            chk("collision", e.tag, 32'(bus.collision), 32'(e.ecol));
            if (e.ea_chk) chk("a_rdata", e.tag, bus.a_rdata, e.ea_d);
            if (e.eb_chk) chk("b_rdata", e.tag, bus.b_rdata, e.eb_d);
        end
    endtask

    vec_t idle;
    exp_t none;

    initial begin
        none = ex(0, 0, 0, 0, 0, 0, 0);
        idle = mk(OP_I, 4'h0, 10'd0, 32'h0, OP_I, 4'h0, 10'd0, 32'h0, none);

        vecs[0]  = mk(OP_I, 4'h0, 10'd0,    32'h0,        OP_W, 4'hF, 10'd5,    32'h11223344, ex(0,0,0,            1,0,0,            0));
        vecs[1]  = mk(OP_R, 4'h0, 10'd5,    32'h0,        OP_I, 4'h0, 10'd0,    32'h0,        ex(1,1,32'h11223344, 0,0,0,            0));
        vecs[2]  = mk(OP_I, 4'h0, 10'd0,    32'h0,        OP_W, 4'hF, 10'd7,    32'h0,        ex(0,0,0,            1,0,0,            0));
        vecs[3]  = mk(OP_W, 4'h5, 10'd7,    32'hAABBCCDD, OP_I, 4'h0, 10'd0,    32'h0,        ex(1,1,32'h00BB00DD, 0,0,0,            0));
        vecs[4]  = mk(OP_R, 4'h0, 10'd7,    32'h0,        OP_I, 4'h0, 10'd0,    32'h0,        ex(1,1,32'h00BB00DD, 0,0,0,            0));
        vecs[5]  = mk(OP_I, 4'h0, 10'd0,    32'h0,        OP_W, 4'hF, 10'd9,    32'h12345678, ex(0,0,0,            1,0,0,            0));
        vecs[6]  = mk(OP_W, 4'hF, 10'd9,    32'hCAFEF00D, OP_I, 4'h0, 10'd0,    32'h0,        ex(1,1,32'hCAFEF00D, 0,0,0,            0));
        vecs[7]  = mk(OP_I, 4'h0, 10'd0,    32'h0,        OP_W, 4'hF, 10'd9,    32'h12345678, ex(0,0,0,            1,1,32'hCAFEF00D, 0));
        vecs[8]  = mk(OP_R, 4'h0, 10'd9,    32'h0,        OP_I, 4'h0, 10'd0,    32'h0,        ex(1,1,32'h12345678, 0,0,0,            0));
        vecs[9]  = mk(OP_W, 4'hF, 10'd4,    32'h1,        OP_W, 4'hF, 10'd3,    32'h0,        ex(1,1,32'h1,        1,0,0,            0));
        vecs[10] = mk(OP_W, 4'h1, 10'd3,    32'h000000FF, OP_W, 4'hF, 10'd3,    32'hFFFFFF00, ex(1,1,32'h000000FF, 1,1,32'h0,        1));
        vecs[11] = mk(OP_R, 4'h0, 10'd3,    32'h0,        OP_I, 4'h0, 10'd0,    32'h0,        ex(1,1,32'hFFFFFFFF, 0,0,0,            0));
        vecs[12] = mk(OP_I, 4'h0, 10'd0,    32'h0,        OP_W, 4'hF, 10'd3,    32'h0,        ex(0,0,0,            1,1,32'hFFFFFFFF, 0));
        vecs[13] = mk(OP_W, 4'h3, 10'd3,    32'h0000AAAA, OP_W, 4'h3, 10'd3,    32'hBBBBBBBB, ex(1,1,32'h0000AAAA, 1,1,32'h0,        1));
        vecs[14] = mk(OP_I, 4'h0, 10'd0,    32'h0,        OP_R, 4'h0, 10'd3,    32'h0,        ex(0,0,0,            1,1,32'h0000AAAA, 0));
        vecs[15] = mk(OP_W, 4'hF, 10'd4,    32'h2,        OP_R, 4'h0, 10'd4,    32'h0,        ex(1,1,32'h2,        1,1,32'h1,        1));
        vecs[16] = mk(OP_R, 4'h0, 10'd4,    32'h0,        OP_I, 4'h0, 10'd0,    32'h0,        ex(1,1,32'h2,        0,0,0,            0));
        vecs[17] = mk(OP_R, 4'h0, 10'd1000, 32'h0,        OP_R, 4'h0, 10'd1000, 32'h0,        ex(1,1,32'h0,        1,1,32'h0,        0));
        vecs[18] = mk(OP_W, 4'hF, 10'd1000, 32'hDEADBEEF, OP_R, 4'h0, 10'd1000, 32'h0,        ex(1,1,32'h0,        1,1,32'h0,        0));
        vecs[19] = mk(OP_W, 4'h0, 10'd5,    32'hDEADBEEF, OP_R, 4'h0, 10'd5,    32'h0,        ex(1,1,32'h11223344, 1,1,32'h11223344, 1));
        vecs[20] = mk(OP_R, 4'h0, 10'd5,    32'h0,        OP_R, 4'h0, 10'd5,    32'h0,        ex(1,1,32'h11223344, 1,1,32'h11223344, 0));
        vecs[21] = mk(OP_I, 4'h0, 10'd0,    32'h0,        OP_W, 4'hF, 10'd999,  32'h5A5A5A5A, ex(0,0,0,            1,0,0,            0));
        vecs[22] = mk(OP_R, 4'h0, 10'd999,  32'h0,        OP_I, 4'h0, 10'd0,    32'h0,        ex(1,1,32'h5A5A5A5A, 0,0,0,            0));
        vecs[23] = mk(OP_R, 4'h0, 10'd1000, 32'h0,        OP_I, 4'h0, 10'd0,    32'h0,        ex(1,1,32'h0,        0,0,0,            0));
        vecs[24] = idle;

        // reset state
        rst = 1'b1;
        bus.a_en = 0; bus.a_we = 0; bus.a_be = '0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_en = 0; bus.b_we = 0; bus.b_be = '0; bus.b_addr = '0; bus.b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_rvalid", -1, 32'(bus.a_rvalid), 32'h0);
        chk("rst_b_rvalid", -1, 32'(bus.b_rvalid), 32'h0);
        chk("rst_a_rdata", -1, bus.a_rdata, 32'h0);
        chk("rst_b_rdata", -1, bus.b_rdata, 32'h0);
        chk("rst_collision", -1, 32'(bus.collision), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) run(vecs[i]);
        repeat (LAT) run(idle);

        // accesses presented during reset are dropped, rdata returns to 0
        rst = 1'b1;
        run(mk(OP_R, 4'h0, 10'd5, 32'h0, OP_W, 4'hF, 10'd5, 32'h0, none));
        chk("rst_drop_a_rdata", -1, bus.a_rdata, 32'h0);
        rst = 1'b0;
        run(mk(OP_R, 4'h0, 10'd5, 32'h0, OP_I, 4'h0, 10'd0, 32'h0, ex(1,1,32'h11223344, 0,0,0, 0)));
        repeat (LAT) run(idle);

`ifdef DMEM_OUT_PIPE_EN
        // reset mid-pipeline flushes the in-flight read; memory keeps its contents
        run(mk(OP_R, 4'h0, 10'd9, 32'h0, OP_R, 4'h0, 10'd9, 32'h0, none));
        rst = 1'b1;
        run(idle);
        rst = 1'b0;
        run(idle);
        run(mk(OP_R, 4'h0, 10'd9, 32'h0, OP_I, 4'h0, 10'd0, 32'h0, ex(1,1,32'h12345678, 0,0,0, 0)));
        repeat (LAT) run(idle);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
